// File: rtl/store_write_buffer_if.sv
// Store-buffer bundle: M-stage store port, load hazard check, memory write channel and status.
// The slave modport is the buffer; the master modport is the pipeline/memory side.
interface store_write_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          st_valid;
   logic [31:0]   st_addr;
   logic [3:0]    st_byteen;
   logic [31:0]   st_wdata;
   logic          st_ready;

   logic          ld_valid;
   logic [31:0]   ld_addr;
   logic          ld_hazard;

   logic          mem_wvalid;
   logic [31:0]   mem_waddr;
   logic [3:0]    mem_byteen;
   logic [31:0]   mem_wdata;
   logic          mem_wready;

   logic          empty;
   logic [CW-1:0] count;

   modport slave (
      input  st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, mem_wready,
      output st_ready, ld_hazard, mem_wvalid, mem_waddr, mem_byteen, mem_wdata, empty, count
   );

   modport master (
      output st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, mem_wready,
      input  st_ready, ld_hazard, mem_wvalid, mem_waddr, mem_byteen, mem_wdata, empty, count
   );
endinterface

// File: rtl/store_write_buffer.sv
// Posted store write buffer: in-order circular FIFO with merge into the newest entry
// and a whole-word load hazard check against buffered and in-flight stores.
module store_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   store_write_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [29:0]   r_word [DEPTH];
   logic [3:0]    r_be   [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [PW-1:0]    w_newest;
   logic [29:0]      w_st_word;
   logic [29:0]      w_ld_word;
   logic             w_st_nz;
   logic             w_empty;
   logic             w_merge_ok;
   logic             w_ready;
   logic             w_push;
   logic             w_merge;
   logic             w_pop;
   logic             w_buf_hit;
   logic [DEPTH-1:0] w_valid;
   logic             w_unused_addr_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                               input logic [31:0] new_d,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_d;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_d[8*i +: 8];
      end
      return res;
   endfunction

   assign w_st_word          = bus.st_addr[31:2];
   assign w_ld_word          = bus.ld_addr[31:2];
   assign w_unused_addr_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
   assign w_st_nz            = (bus.st_byteen != 4'b0000);
   assign w_empty            = (r_count == '0);
   assign w_newest           = r_tail - PW'(1);

   // The count >= 2 guard keeps the head entry immutable while it is being presented.
   assign w_merge_ok = w_st_nz && (r_count >= CW'(2)) && (r_word[w_newest] == w_st_word);
   assign w_ready    = (r_count < CW'(DEPTH)) || w_merge_ok;
   assign w_merge    = bus.st_valid && w_merge_ok;
   assign w_push     = bus.st_valid && w_st_nz && w_ready && !w_merge_ok;
   assign w_pop      = !w_empty && bus.mem_wready;

   // Slot j is live when its distance from head is below the occupancy.
   always_comb begin
      w_valid   = '0;
      w_buf_hit = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         w_valid[j] = ({1'b0, PW'(j) - r_head} < r_count);
         if (w_valid[j] && (r_word[j] == w_ld_word)) w_buf_hit = 1'b1;
      end
   end

   assign bus.st_ready   = w_ready;
   assign bus.ld_hazard  = bus.ld_valid &&
                           (w_buf_hit || (bus.st_valid && w_st_nz && (w_st_word == w_ld_word)));
   assign bus.empty      = w_empty;
   assign bus.count      = r_count;
   assign bus.mem_wvalid = !w_empty;
   assign bus.mem_waddr  = w_empty ? 32'h0 : {r_word[r_head], 2'b00};
   assign bus.mem_byteen = w_empty ? 4'h0  : r_be[r_head];
   assign bus.mem_wdata  = w_empty ? 32'h0 : r_data[r_head];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage needs no reset: liveness comes solely from head/count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_word[r_tail] <= w_st_word;
         r_be[r_tail]   <= bus.st_byteen;
         r_data[r_tail] <= bus.st_wdata;
      end else if (w_merge) begin
         r_be[w_newest]   <= r_be[w_newest] | bus.st_byteen;
         r_data[w_newest] <= merge_bytes(r_data[w_newest], bus.st_wdata, bus.st_byteen);
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: queue-level reference model checked every cycle,
// plus literal expectations for ordering, merge, head protection, hazards and reset.
module tb_store_write_buffer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [29:0] w;
      logic [3:0]  be;
      logic [31:0] d;
   } ent_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   bit   chk_en = 1'b0;

   ent_t q[$];
   ent_t wlog[$];
   int   wcyc[$];
   logic [31:0] exp_a[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};

   store_write_buffer_if #(.DEPTH(DEPTH)) bus();

   store_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      ent_t e;
      e.w  = a[31:2];
      e.be = be;
      e.d  = d;
      return e;
   endfunction

   // Reference model: a plain queue of entries, newest at the back.
   function automatic bit m_merge_ok();
      if (q.size() < 2 || bus.st_byteen == 4'h0) return 1'b0;
      return q[q.size()-1].w == bus.st_addr[31:2];
   endfunction

   function automatic bit m_ready();
      return (q.size() < DEPTH) || m_merge_ok();
   endfunction

   function automatic bit m_hazard();
      bit hit;
      hit = 1'b0;
      foreach (q[i]) if (q[i].w == bus.ld_addr[31:2]) hit = 1'b1;
      if (bus.st_valid && bus.st_byteen != 4'h0 && bus.st_addr[31:2] == bus.ld_addr[31:2])
         hit = 1'b1;
      return bus.ld_valid && hit;
   endfunction

   always @(posedge clk) begin
      bit   mg, ps, pp;
      ent_t e;
      cyc++;
      if (reset) begin
         q.delete();
      end else begin
         if (bus.mem_wvalid && bus.mem_wready) begin
            wlog.push_back(ent_t'({bus.mem_waddr[31:2], bus.mem_byteen, bus.mem_wdata}));
            wcyc.push_back(cyc);
         end
         mg = bus.st_valid && m_merge_ok();
         ps = bus.st_valid && bus.st_byteen != 4'h0 && !mg && q.size() < DEPTH;
         pp = (q.size() != 0) && bus.mem_wready;
         if (mg) begin
            e = q[q.size()-1];
            for (int i = 0; i < 4; i++) begin
               if (bus.st_byteen[i]) e.d[8*i +: 8] = bus.st_wdata[8*i +: 8];
            end
            e.be = e.be | bus.st_byteen;
            q[q.size()-1] = e;
         end
         if (pp) void'(q.pop_front());
         if (ps) q.push_back(mk(bus.st_addr, bus.st_byteen, bus.st_wdata));
      end
   end

   always @(negedge clk) begin
      ent_t h;
      if (chk_en) begin
         h = (q.size() != 0) ? q[0] : '0;
         chk("m_empty",     64'(bus.empty),      64'(q.size() == 0));
         chk("m_count",     64'(bus.count),      64'(q.size()));
         chk("m_wvalid",    64'(bus.mem_wvalid), 64'(q.size() != 0));
         chk("m_waddr",     64'(bus.mem_waddr),  64'({h.w, 2'b00}));
         chk("m_byteen",    64'(bus.mem_byteen), 64'(h.be));
         chk("m_wdata",     64'(bus.mem_wdata),  64'(h.d));
         chk("m_st_ready",  64'(bus.st_ready),   64'(m_ready()));
         chk("m_ld_hazard", 64'(bus.ld_hazard),  64'(m_hazard()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      bus.st_valid  = 1'b1;
      bus.st_addr   = a;
      bus.st_byteen = be;
      bus.st_wdata  = d;
      step();
      bus.st_valid  = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      bus.mem_wready = 1'b1;
      while (!bus.empty && k < 20) begin
         step();
         k++;
      end
      chk({name, "_drain_done"}, 64'(bus.empty), 64'(1));
      bus.mem_wready = 1'b0;
   endtask

   initial begin
      bus.st_valid   = 1'b0;
      bus.st_addr    = '0;
      bus.st_byteen  = '0;
      bus.st_wdata   = '0;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
      bus.mem_wready = 1'b0;

      reset = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_empty",    64'(bus.empty),      64'(1));
      chk("rst_count",    64'(bus.count),      64'(0));
      chk("rst_wvalid",   64'(bus.mem_wvalid), 64'(0));
      chk("rst_st_ready", 64'(bus.st_ready),   64'(1));

      store(32'h100, 4'hF, 32'h11111111);
      store(32'h104, 4'h1, 32'h000000AA);
      store(32'h108, 4'hF, 32'h22222222);
      store(32'h10C, 4'hF, 32'h33333333);
      chk("ord_count4", 64'(bus.count), 64'(4));
      bus.st_valid = 1'b1; bus.st_addr = 32'h200; bus.st_byteen = 4'hF; bus.st_wdata = 32'h5;
      #1;
      chk("ord_full_not_ready", 64'(bus.st_ready), 64'(0));
      bus.st_valid = 1'b0;
      wlog.delete(); wcyc.delete();
      drain("ord");
      chk("ord_nwrites", 64'(wlog.size()), 64'(4));
      if (wlog.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("ord_addr%0d", i), 64'({wlog[i].w, 2'b00}), 64'(exp_a[i]));
            chk($sformatf("ord_cycle%0d", i), 64'(wcyc[i] - wcyc[0]), 64'(i));
         end
         chk("ord_entry1", 64'(wlog[1]), 64'(mk(32'h104, 4'h1, 32'h000000AA)));
      end

      store(32'h100, 4'hF, 32'h11111111);
      store(32'h104, 4'h1, 32'h000000AA);
      store(32'h106, 4'hC, 32'hBEEF0000);
      chk("mrg_count2", 64'(bus.count), 64'(2));
      wlog.delete(); wcyc.delete();
      drain("mrg");
      chk("mrg_nwrites", 64'(wlog.size()), 64'(2));
      if (wlog.size() == 2) begin
         chk("mrg_first",  64'(wlog[0]), 64'(mk(32'h100, 4'hF, 32'h11111111)));
         chk("mrg_second", 64'(wlog[1]), 64'(mk(32'h104, 4'hD, 32'hBEEF00AA)));
      end

      store(32'h200, 4'hF, 32'h12345678);
      store(32'h200, 4'h2, 32'h00003300);
      chk("head_count2",  64'(bus.count),      64'(2));
      chk("head_wdata",   64'(bus.mem_wdata),  64'(32'h12345678));
      chk("head_byteen",  64'(bus.mem_byteen), 64'(4'hF));
      step();
      chk("head_stable",  64'(bus.mem_wdata),  64'(32'h12345678));
      wlog.delete(); wcyc.delete();
      drain("head");
      chk("head_nwrites", 64'(wlog.size()), 64'(2));
      if (wlog.size() == 2) begin
         chk("head_w0", 64'(wlog[0]), 64'(mk(32'h200, 4'hF, 32'h12345678)));
         chk("head_w1", 64'(wlog[1]), 64'(mk(32'h200, 4'h2, 32'h00003300)));
      end

      store(32'h300, 4'hF, 32'hCAFE0000);
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h302;
      #1;
      chk("haz_buffered", 64'(bus.ld_hazard), 64'(1));
      bus.ld_addr = 32'h304;
      #1;
      chk("haz_miss", 64'(bus.ld_hazard), 64'(0));
      drain("haz");
      bus.st_valid = 1'b1; bus.st_addr = 32'h304; bus.st_byteen = 4'hF; bus.st_wdata = 32'h1;
      #1;
      chk("haz_inflight", 64'(bus.ld_hazard), 64'(1));
      step();
      bus.st_valid = 1'b0;
      bus.ld_valid = 1'b0;
      drain("haz2");

      store(32'h400, 4'hF, 32'h00000044);
      store(32'h404, 4'h0, 32'h00000055);
      chk("zero_en_count", 64'(bus.count), 64'(1));
      store(32'h408, 4'hF, 32'h00000066);
      store(32'h40C, 4'hF, 32'h00000077);
      chk("rstmid_count3", 64'(bus.count),      64'(3));
      chk("rstmid_wvalid", 64'(bus.mem_wvalid), 64'(1));
      wlog.delete(); wcyc.delete();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rstmid_empty",   64'(bus.empty),      64'(1));
      chk("rstmid_wvalid0", 64'(bus.mem_wvalid), 64'(0));
      bus.mem_wready = 1'b1;
      repeat (4) step();
      chk("rstmid_no_writes", 64'(wlog.size()), 64'(0));
      bus.mem_wready = 1'b0;
      step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Posted write buffer between the store byte-lane placement stage and the data-memory/bus write port. It accepts lane-placed stores (word address, byte enables, data) from the M stage and drains them in program order over a valid/ready write channel, so that a slow memory only stalls the pipeline when the buffer is full. Consecutive stores to the same word are merged, and loads that hit a buffered word are flagged so the pipeline can stall until that word has drained.

## Interface
Parameters:
- DEPTH, 4, number of entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  M-stage store request this cycle
- st_addr  in  32  store byte address; only [31:2] used
- st_byteen  in  4  byte enables from store lane placement
- st_wdata  in  32  lane-placed store data
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  load address check request
- ld_addr  in  32  load byte address; only [31:2] used
- ld_hazard  out  1  load word is buffered or being stored; stall
- mem_wvalid  out  1  head entry is presented
- mem_waddr  out  32  head word address, bits [1:0] = 0
- mem_byteen  out  4  head byte enables
- mem_wdata  out  32  head data
- mem_wready  in  1  memory accepts the write
- empty  out  1  no valid entries
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Circular FIFO: head and tail pointers plus count. Each entry holds word address [31:2], byteen[3:0] and data[31:0].
- Push: occurs on st_valid && st_ready && st_byteen != 0. The store is written at the tail and count increments.
- Zero-enable stores: st_valid with st_byteen == 0 is consumed and dropped. No entry is created and there is no merge.
- Merge: applies when the store word equals the word of the newest entry (tail-1) and count ≥ 2. The store merges into that entry instead of pushing: for each lane i with st_byteen[i]=1, data byte i is replaced; entry byteen becomes old | new; count is unchanged. The head entry is never merged, so presented data stays stable.
- st_ready = (count < DEPTH) || merge-eligible. The ready decision ignores a same-cycle pop; there is no full-bypass.
- Pop: occurs on mem_wvalid && mem_wready. Head advances and count decrements.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Write channel:
  - mem_wvalid = !empty.
  - mem_waddr/mem_byteen/mem_wdata are driven from the head entry.
  - All are held stable while mem_wvalid && !mem_wready.
- ld_hazard = ld_valid && (any valid entry with word == ld_addr[31:2], or st_valid && st_byteen != 0 && st_addr[31:2] == ld_addr[31:2]). The check is on the whole word regardless of which bytes are buffered.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (synchronous, on a clk edge while reset=1):
  - count=0, pointers=0, all entries invalid.
  - Resulting outputs: empty=1, mem_wvalid=0, mem_waddr/mem_byteen/mem_wdata=0, st_ready=1, ld_hazard=0 unless the same-cycle store term applies.
- Reset mid-operation discards all buffered stores, including any entry presented with mem_wvalid=1 and not yet accepted.
- Store-to-memory latency: a store accepted at edge N appears on mem_w* in cycle N+1 when the buffer was empty. Otherwise it appears after all older entries have popped, one pop per cycle at most.
- st_ready, ld_hazard, mem_wvalid and empty are combinational from registered state and the current inputs listed above. count is registered.
- A merged entry's new contents are visible from the cycle after the merge edge.

## Test plan
- Reset: assert reset for 2 cycles with mem_wready=0 -> empty=1, count=0, mem_wvalid=0, st_ready=1.
- Ordering, with DEPTH=4 and mem_wready=0:
  - Push stores to 0x100/1111/0x11111111, 0x104/0001/0x000000AA, 0x108, 0x10C -> count=4, st_ready=0 for an unrelated address.
  - Raise mem_wready -> words 0x100, 0x104, 0x108, 0x10C are written on 4 consecutive cycles, then empty=1.
- Merge, with mem_wready=0:
  - Push 0x100/1111/0x11111111, then 0x104/0001/0x000000AA, then 0x106/1100/0xBEEF0000 -> count=2.
  - Drain -> second write is 0x104/1101/0xBEEF00AA.
- No merge at head: with count=1, head at 0x200 and mem_wready=0, push 0x200/0010/0x00003300 -> count=2, and head data is unchanged while presented.
- Hazard:
  - 0x300 buffered, ld_valid=1, ld_addr=0x302 -> ld_hazard=1.
  - ld_addr=0x304 -> ld_hazard=0.
  - Empty buffer, st_valid=1 with store to 0x304, ld_addr=0x304 -> ld_hazard=1.
- Zero-enable store and reset mid-drain:
  - st_byteen=0 store -> count unchanged.
  - With 3 entries and mem_wvalid=1, pulse reset -> next cycle empty=1, mem_wvalid=0, and no further writes are issued.
